led_stretcher: RTL

Output-side counterpart to the push-button debouncer: it drives user LEDs from internal event or level signals. Each channel is stretched so that even a single-clock event stays visible for a fixed hold time. All channels are dimmed by a shared PWM brightness control. It sits between status/event logic in the fabric and the board LED pins.

---
 rtl/led_stretcher.sv | 135 +++++++++++++
 1 files changed

// File: rtl/led_stretcher.sv
// -----------------------------------------------------------------------------
// led_stretcher
//
// Drives board LEDs from internal event or level signals. Each channel has its
// own hold timer, so a request lasting a single clock still lights the LED for
// HOLD_MAX = 2^LGHOLD - 1 clocks. Every request (re)loads the timer. All lit
// channels are gated by one shared, free-running PWM so a single brightness
// value dims the whole bank.
//
// Parameters
//   NLED   : number of independent LED channels
//   LGHOLD : width of each hold timer (hold time is 2^LGHOLD - 1 clocks)
//   LGPWM  : width of the PWM counter and of i_brightness
//
// Ports
//   i_clk        : system clock; every input is synchronous to it
//   i_reset      : synchronous, active-high reset
//   i_led        : per-channel request; any high cycle (re)arms that channel
//   i_brightness : duty control; 0 = off, all-ones = always on
//   o_led        : registered LED drive (stretched AND pwm gate)
//   o_busy       : registered; high while any hold timer is nonzero
// -----------------------------------------------------------------------------
module led_stretcher #(
  parameter int NLED   = 8,
  parameter int LGHOLD = 22,
  parameter int LGPWM  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NLED-1:0]   i_led,
  input  logic [LGPWM-1:0]  i_brightness,
  output logic [NLED-1:0]   o_led,
  output logic              o_busy
);

  // Reload value is exactly all-ones of the timer width.
  localparam logic [LGHOLD-1:0] HOLD_MAX = '1;

  // Per-channel state. The timer register is the real state; IDLE/HOLD is a
  // decoded view of it that keeps the next-state logic readable.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_HOLD = 1'b1
  } ch_state_e;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  logic [LGHOLD-1:0] timer_q [NLED];
  logic [LGHOLD-1:0] timer_d [NLED];
  logic [LGPWM-1:0]  pwm_cnt_q;
  logic [LGPWM-1:0]  pwm_cnt_d;
  logic [NLED-1:0]   led_q;
  logic [NLED-1:0]   led_d;
  logic              busy_q;
  logic              busy_d;

  // Combinational views of the current register state.
  ch_state_e         ch_state [NLED];
  logic [NLED-1:0]   stretched;
  logic              pwm_on;

  // ---------------------------------------------------------------------------
  // Hold timers: request reloads, otherwise count down to zero and stop.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves a value unassigned and no latch can be inferred.
    for (int k = 0; k < NLED; k++) begin
      timer_d[k]   = timer_q[k];
      ch_state[k]  = CH_IDLE;
      stretched[k] = 1'b0;

      if (timer_q[k] != '0) begin
        ch_state[k] = CH_HOLD;
      end
      stretched[k] = (ch_state[k] == CH_HOLD);

      // Retrigger while counting behaves exactly like a first arm.
      if (i_led[k]) begin
        timer_d[k] = HOLD_MAX;
      end else if (ch_state[k] == CH_HOLD) begin
        // Decrement only from a nonzero value, so the timer never wraps.
        timer_d[k] = timer_q[k] - LGHOLD'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PWM: free-running counter, compared against the live brightness value.
  // All-ones is forced fully on; the compare alone would give one dark cycle
  // per period at that setting.
  // ---------------------------------------------------------------------------
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + LGPWM'(1);
    pwm_on    = (&i_brightness) || (pwm_cnt_q < i_brightness);
  end

  // ---------------------------------------------------------------------------
  // Output next-state. Busy ignores brightness; it reports timer activity.
  // ---------------------------------------------------------------------------
  always_comb begin
    led_d  = stretched & {NLED{pwm_on}};
    busy_d = |stretched;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: the timers are a small array of flops, not a RAM, so resetting
      // them is cheap and required; a request in the reset cycle is dropped.
      for (int k = 0; k < NLED; k++) begin
        timer_q[k] <= '0;
      end
      pwm_cnt_q <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      for (int k = 0; k < NLED; k++) begin
        timer_q[k] <= timer_d[k];
      end
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;

endmodule
